image_frame_writer: RTL and testbench

Streaming pixel capture block that sits ahead of the average-pooling stage. It accepts a raster-order pixel stream through a valid/ready handshake and writes each pixel into a flattened frame vector. Pixel index p = row·COLS + col occupies bits [p·RESOLUTION +: RESOLUTION]. When the frame is complete, the block holds it stable for the pooling/MLP datapath until the consumer acknowledges it.

---
 rtl/image_frame_writer_if.sv | 24 ++
 rtl/image_frame_writer.sv | 116 +++++++++++
 tb/tb_image_frame_writer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_frame_writer_if.sv
// Raster pixel stream handshake between a pixel source and image_frame_writer.
// The master drives pixels and start-of-frame; the slave answers with ready.
interface image_frame_writer_if #(
    parameter int RESOLUTION = 8
) ();
    logic [RESOLUTION-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_sof;
    logic                  pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        output pix_ready
    );
endinterface

// File: rtl/image_frame_writer.sv
// Captures a raster pixel stream into a flattened frame and holds it until acknowledged.
// Optional start-of-frame resynchronisation is enabled by defining FRAME_SOF_SYNC_EN.
module image_frame_writer #(
    parameter int RESOLUTION = 8,
    parameter int ROWS       = 28,
    parameter int COLS       = 28
) (
    input  logic                             clk,
    input  logic                             reset,
    image_frame_writer_if.slave              pix_if,
    output logic [RESOLUTION*ROWS*COLS-1:0]  image,
    output logic                             frame_valid,
    input  logic                             frame_ack,
    output logic [15:0]                      pix_count,
    output logic                             sync_err
);

    localparam int IMG_W = RESOLUTION * ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [15:0]        pix_count_q, pix_count_d;
    logic [IMG_W-1:0]   image_q, image_d;
    logic               sync_err_q, sync_err_d;
    logic               sof_hit;
    int                 wr_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_q       <= '0;
            pix_count_q <= '0;
            image_q     <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pix_count_q <= pix_count_d;
            image_q     <= image_d;
            sync_err_q  <= sync_err_d;
        end
    end

`ifdef FRAME_SOF_SYNC_EN
    assign sof_hit = pix_if.pix_sof;
`else
    assign sof_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        pix_count_d = pix_count_q;
        image_d     = image_q;
        sync_err_d  = 1'b0;
        wr_idx      = int'(row_q) * COLS + int'(col_q);

        unique case (state_q)
            FILL: begin
                if (pix_if.pix_valid) begin
                    // A start-of-frame pixel always restarts alignment, even on the last slot.
                    if (sof_hit) begin
                        image_d[0 +: RESOLUTION] = pix_if.pix_data;
                        row_d       = '0;
                        col_d       = COL_W'(1);
                        pix_count_d = 16'd1;
                        sync_err_d  = (pix_count_q != 16'd0);
                    end else begin
                        image_d[wr_idx*RESOLUTION +: RESOLUTION] = pix_if.pix_data;
                        pix_count_d = pix_count_q + 16'd1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                row_d       = '0;
                                pix_count_d = '0;
                                state_d     = HOLD;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        pix_if.pix_ready = (state_q == FILL);
        frame_valid      = (state_q == HOLD);
        image            = image_q;
        pix_count        = pix_count_q;
        sync_err         = sync_err_q;
    end

endmodule

// File: tb/tb_image_frame_writer.sv
// Directed bench for image_frame_writer: step table, spot-check table and
// hand-written sequences for hold, ack, bubbles, mid-frame reset and SOF.
module tb_image_frame_writer;

    localparam int RES   = 8;
    localparam int ROWS  = 28;
    localparam int COLS  = 28;
    localparam int NPIX  = ROWS * COLS;
    localparam int IMG_W = RES * NPIX;

`ifdef FRAME_SOF_SYNC_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic        ack;
        logic [7:0]  data;
        logic        exp_ready;
        logic        exp_fvalid;
        logic [15:0] exp_count;
    } step_t;

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } spot_t;

    logic             clk;
    logic             reset;
    logic [IMG_W-1:0] image;
    logic             frame_valid;
    logic             frame_ack;
    logic [15:0]      pix_count;
    logic             sync_err;

    image_frame_writer_if #(.RESOLUTION(RES)) pix_if ();

    image_frame_writer #(
        .RESOLUTION(RES),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_if     (pix_if),
        .image      (image),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .pix_count  (pix_count),
        .sync_err   (sync_err)
    );

    // Reference model state, advanced by the bench at every driven clock edge
    logic [IMG_W-1:0] exp_image;
    int               m_count;
    bit               m_hold;
    bit               m_sync;

    int passed;
    int total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic checkImage(input string name, input logic [IMG_W-1:0] want);
        total++;
        if (image !== want) begin
            for (int i = 0; i < NPIX; i++) begin
                if (image[i*RES +: RES] !== want[i*RES +: RES]) begin
                    $display("[TB] FAIL %s_image: pixel %0d got %0h expected %0h",
                             name, i, image[i*RES +: RES], want[i*RES +: RES]);
                    break;
                end
            end
        end else begin
            passed++;
        end
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, "_ready"}, 32'(pix_if.pix_ready), 32'(!m_hold));
        checkVal({name, "_fvalid"}, 32'(frame_valid), 32'(m_hold));
        checkVal({name, "_count"}, 32'(pix_count), 32'(m_count));
        checkVal({name, "_sync"}, 32'(sync_err), 32'(m_sync));
        checkImage(name, exp_image);
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s, input logic a);
        pix_if.pix_valid = v;
        pix_if.pix_data  = d;
        pix_if.pix_sof   = s;
        frame_ack        = a;
        @(posedge clk);
        m_sync = 1'b0;
        if (!m_hold) begin
            if (v) begin
                if (SOF_EN && s) begin
                    exp_image[0 +: RES] = d;
                    m_sync  = (m_count != 0);
                    m_count = 1;
                end else begin
                    exp_image[m_count*RES +: RES] = d;
                    if (m_count == NPIX - 1) begin
                        m_count = 0;
                        m_hold  = 1'b1;
                    end else begin
                        m_count++;
                    end
                end
            end
        end else if (a) begin
            m_hold = 1'b0;
        end
        #1;
    endtask

    task automatic doReset(input logic v, input logic [7:0] d);
        pix_if.pix_valid = v;
        pix_if.pix_data  = d;
        pix_if.pix_sof   = 1'b0;
        frame_ack        = 1'b0;
        reset            = 1'b1;
        @(posedge clk);
        m_count   = 0;
        m_hold    = 1'b0;
        m_sync    = 1'b0;
        exp_image = '0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        step_t steps[6];
        spot_t spots[8];
        logic [IMG_W-1:0] all_ff;
        logic [IMG_W-1:0] held;
        int p;
        int cyc;

        // Frame start: idle cycle, ack ignored while filling, a bubble
        steps[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        steps[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd1};
        steps[2] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 16'd2};
        steps[3] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 16'd2};
        steps[4] = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 16'd3};
        steps[5] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 16'd4};

        // Bubble frame stores (3p+7) mod 256; these straddle the row wraps
        spots[0] = '{0,   8'd7};
        spots[1] = '{26,  8'd85};
        spots[2] = '{27,  8'd88};
        spots[3] = '{28,  8'd91};
        spots[4] = '{55,  8'd172};
        spots[5] = '{56,  8'd175};
        spots[6] = '{755, 8'd224};
        spots[7] = '{783, 8'd52};

        passed = 0;
        total  = 0;
        all_ff = '1;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = '0;
        pix_if.pix_sof   = 1'b0;
        frame_ack        = 1'b0;
        reset            = 1'b1;
        @(posedge clk);
        doReset(1'b0, 8'h00);
        checkOutput("reset");

        $display("[TB] full frame");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(steps[i].valid, steps[i].data, 1'b0, steps[i].ack);
            checkVal($sformatf("step%0d_ready", i), 32'(pix_if.pix_ready), 32'(steps[i].exp_ready));
            checkVal($sformatf("step%0d_fvalid", i), 32'(frame_valid), 32'(steps[i].exp_fvalid));
            checkVal($sformatf("step%0d_count", i), 32'(pix_count), 32'(steps[i].exp_count));
            checkOutput($sformatf("step%0d", i));
        end
        for (int i = 4; i < NPIX; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("frame1");
        end
        checkVal("frame1_last_fvalid", 32'(frame_valid), 32'd1);
        checkVal("frame1_last_ready", 32'(pix_if.pix_ready), 32'd0);
        checkVal("frame1_pix29", 32'(image[29*8 +: 8]), 32'd29);
        checkVal("frame1_pix783", 32'(image[783*8 +: 8]), 32'd15);

        $display("[TB] hold with backpressure");
        held = exp_image;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
            checkOutput("hold");
            checkVal("hold_count", 32'(pix_count), 32'd0);
        end
        checkImage("hold_unchanged", held);

        $display("[TB] ack and refill");
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        checkOutput("ack1");
        checkVal("ack1_ready", 32'(pix_if.pix_ready), 32'd1);
        checkVal("ack1_fvalid", 32'(frame_valid), 32'd0);
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
            checkOutput("frame2");
        end
        checkImage("frame2_all_ff", all_ff);
        checkVal("frame2_fvalid", 32'(frame_valid), 32'd1);

        $display("[TB] bubbles");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ack2");
        p   = 0;
        cyc = 0;
        while (!m_hold && cyc < 2000) begin
            if (cyc % 3 != 2) begin
                applyStimulus(1'b1, 8'(p * 3 + 7), 1'b0, 1'b0);
                p++;
            end else begin
                applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0);
            end
            checkOutput("bubble");
            cyc++;
        end
        checkVal("bubble_fvalid", 32'(frame_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkVal($sformatf("spot%0d", spots[i].idx),
                     32'(image[spots[i].idx*8 +: 8]), 32'(spots[i].exp));
        end

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ack3");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
            checkOutput("partial");
        end
        doReset(1'b1, 8'h99);
        checkOutput("midreset");
        checkVal("midreset_count", 32'(pix_count), 32'd0);
        checkImage("midreset_zero", '0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("after_reset");
        checkVal("after_reset_pix0", 32'(image[7:0]), 32'h3C);

        $display("[TB] start-of-frame marker");
        for (int i = 1; i < 100; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("pre_sof");
        end
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("sof");
`ifdef FRAME_SOF_SYNC_EN
        checkVal("sof_sync_err", 32'(sync_err), 32'd1);
        checkVal("sof_pix0", 32'(image[7:0]), 32'h55);
        checkVal("sof_count", 32'(pix_count), 32'd1);
`else
        checkVal("sof_sync_err", 32'(sync_err), 32'd0);
        checkVal("sof_pix100", 32'(image[100*8 +: 8]), 32'h55);
        checkVal("sof_count", 32'(pix_count), 32'd101);
`endif
        p = 0;
        while (!m_hold && p < NPIX) begin
            applyStimulus(1'b1, 8'(p + 200), 1'b0, 1'b0);
            checkOutput("post_sof");
            checkVal("post_sof_sync", 32'(sync_err), 32'd0);
            p++;
        end
        checkVal("post_sof_fvalid", 32'(frame_valid), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
